// File: rtl/demux_dispatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// demux_dispatch_ctrl_if
// Bundles the producer handshake, the per-channel consumer handshake and the
// controller status outputs of demux_dispatch_ctrl into one interface.
//
// Signals:
//   in_valid / in_data / in_dest / in_ready : producer valid/ready handshake
//   mode, ch_en                             : dispatch policy and channel mask
//   sel, out_data, out_valid, out_ready     : demux select, data and per-channel
//                                             one-hot valid / acknowledge
//   busy, sent_cnt, drop_pulse              : status
//
// Modports:
//   master : the dispatch controller (drives ready, select, data, valid, status)
//   slave  : the surrounding producer / consumers
// ---------------------------------------------------------------------------
interface demux_dispatch_ctrl_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [1:0]    in_dest;
   logic          in_ready;
   logic          mode;
   logic [3:0]    ch_en;
   logic [1:0]    sel;
   logic [DW-1:0] out_data;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic          busy;
   logic [7:0]    sent_cnt;
   logic          drop_pulse;

   modport master (
      input  in_valid, in_data, in_dest, mode, ch_en, out_ready,
      output in_ready, sel, out_data, out_valid, busy, sent_cnt, drop_pulse
   );

   modport slave (
      output in_valid, in_data, in_dest, mode, ch_en, out_ready,
      input  in_ready, sel, out_data, out_valid, busy, sent_cnt, drop_pulse
   );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// demux_dispatch_ctrl
// Sequences a shared 1-to-4 demux. One word at a time is accepted from the
// producer, a destination channel is chosen (round-robin over enabled
// channels when mode=0, or in_dest when mode=1), and the word is presented on
// that channel with a one-hot valid until the channel acknowledges.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux_dispatch_ctrl_if.master
//           in_valid/in_data/in_dest/in_ready - producer handshake
//           mode/ch_en                        - dispatch policy and channel mask
//           sel/out_data/out_valid/out_ready  - demux select, held word,
//                                               one-hot valid, per-channel ack
//           busy/sent_cnt/drop_pulse          - status
//
// Parameters:
//   DW      : data word width (must match the interface DW)
//   TIMEOUT : HOLD cycles without ack before the word is dropped
//
// Optional build macro DISPATCH_TIMEOUT_EN:
//   defined   - a held word that sees no ack for TIMEOUT cycles is dropped and
//               drop_pulse fires for one cycle
//   undefined - HOLD waits indefinitely and drop_pulse is tied low
// ---------------------------------------------------------------------------
module demux_dispatch_ctrl #(
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   demux_dispatch_ctrl_if.master  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // A zero timeout would drop every word before any consumer could respond.
   if (TIMEOUT < 1) begin : g_timeout_check
      $error("demux_dispatch_ctrl: TIMEOUT must be at least 1");
   end

   // Round-robin pick: first enabled channel at ptr+1, ptr+2, ptr+3, ptr+4
   // (mod 4). Returns {found, channel}. Scanning downwards and overwriting
   // leaves the nearest hit.
   function automatic logic [2:0] rr_pick(input logic [1:0] ptr,
                                          input logic [3:0] en);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = ptr + 2'(k);
         if (en[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_t        state_r, state_s;
   logic [1:0]    sel_r, sel_s;
   logic [DW-1:0] out_data_r, out_data_s;
   logic [3:0]    out_valid_r, out_valid_s;
   logic          busy_r, busy_s;
   logic [7:0]    sent_cnt_r, sent_cnt_s;
   logic [1:0]    rr_ptr_r, rr_ptr_s;

   logic [2:0]    rr_pick_s;
   logic [1:0]    target_s;
   logic          legal_s;
   logic          in_ready_s;
   logic          accept_s;
   logic          ack_s;
   logic          tmo_hit_s;

   assign rr_pick_s = rr_pick(rr_ptr_r, bus.ch_en);

   // Target selection and legality for the word currently offered.
   always_comb begin
      target_s = 2'd0;
      legal_s  = 1'b0;
      if (bus.mode) begin
         target_s = bus.in_dest;
         legal_s  = bus.ch_en[bus.in_dest];
      end else begin
         target_s = rr_pick_s[1:0];
         legal_s  = rr_pick_s[2];
      end
   end

   // in_ready is combinational so a stalled producer sees mode/in_dest/ch_en
   // changes in the same cycle; nothing is latched while it stalls.
   assign in_ready_s = (state_r == ST_IDLE) && legal_s;
   assign accept_s   = bus.in_valid && in_ready_s;
   // Only the selected channel's acknowledge matters.
   assign ack_s      = bus.out_ready[sel_r];

   // Next-state and next-output logic for the dispatch FSM.
   always_comb begin
      state_s     = state_r;
      sel_s       = sel_r;
      out_data_s  = out_data_r;
      out_valid_s = out_valid_r;
      busy_s      = busy_r;
      sent_cnt_s  = sent_cnt_r;
      rr_ptr_s    = rr_ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s     = ST_HOLD;
               sel_s       = target_s;
               out_data_s  = bus.in_data;
               out_valid_s = 4'b0001 << target_s;
               busy_s      = 1'b1;
               if (!bus.mode) begin
                  rr_ptr_s = target_s;
               end else begin
                  rr_ptr_s = rr_ptr_r;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // Ack wins over a coincident timeout.
            if (ack_s) begin
               state_s     = ST_IDLE;
               out_valid_s = 4'b0000;
               busy_s      = 1'b0;
               sent_cnt_s  = sent_cnt_r + 8'd1;
            end else if (tmo_hit_s) begin
               // rr_ptr keeps the dropped channel so the next grant moves on.
               state_s     = ST_IDLE;
               out_valid_s = 4'b0000;
               busy_s      = 1'b0;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            out_valid_s = 4'b0000;
            busy_s      = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered outputs and round-robin pointer; rr_ptr resets to 3 so the
   // first round-robin grant lands on channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_r       <= 2'd0;
         out_data_r  <= {DW{1'b0}};
         out_valid_r <= 4'b0000;
         busy_r      <= 1'b0;
         sent_cnt_r  <= 8'd0;
         rr_ptr_r    <= 2'd3;
      end else begin
         sel_r       <= sel_s;
         out_data_r  <= out_data_s;
         out_valid_r <= out_valid_s;
         busy_r      <= busy_s;
         sent_cnt_r  <= sent_cnt_s;
         rr_ptr_r    <= rr_ptr_s;
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
   logic             drop_s;
   logic             drop_pulse_r;

   // The edge that would take the counter to TIMEOUT is the drop edge, so a
   // word is held for exactly TIMEOUT cycles without ack.
   assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

   // Timeout counter next value and drop detection.
   always_comb begin
      tmo_cnt_s = tmo_cnt_r;
      drop_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               tmo_cnt_s = {TMO_W{1'b0}};
            end else begin
               tmo_cnt_s = tmo_cnt_r;
            end
         end
         ST_HOLD: begin
            if (ack_s) begin
               tmo_cnt_s = tmo_cnt_r;
            end else if (tmo_hit_s) begin
               drop_s = 1'b1;
            end else begin
               tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
            end
         end
         default: begin
            tmo_cnt_s = {TMO_W{1'b0}};
         end
      endcase
   end

   // Timeout counter and one-cycle drop pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r    <= {TMO_W{1'b0}};
         drop_pulse_r <= 1'b0;
      end else begin
         tmo_cnt_r    <= tmo_cnt_s;
         drop_pulse_r <= drop_s;
      end
   end

   assign bus.drop_pulse = drop_pulse_r;
`else
   assign tmo_hit_s      = 1'b0;
   assign bus.drop_pulse = 1'b0;
`endif

   assign bus.in_ready  = in_ready_s;
   assign bus.sel       = sel_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.sent_cnt  = sent_cnt_r;

endmodule
